stack_engine: RTL

- Parametrised hardware stack sequencer for the 6502 core. Executes multi-byte push, pull and SP-load commands against the memory bus, one byte per cycle.
- Generalises the single-byte PHA/PLA stack path to configurable data width, SP width and stack base. Supports 1..MAX_BYTES byte bursts: JSR (2), BRK/IRQ (3), RTI pull (3).
- Offers selectable wrap or guarded overflow mode.
- Sits between the control FSM and the mem block.

---
 rtl/stack_engine.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/stack_engine.sv
// Multi-byte stack sequencer for the 6502 core: push, pull and SP load against the memory
// bus, one byte per cycle, with either 6502-style SP wrap or guarded (rejecting) mode.
module stack_engine #(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       SP_W       = 8,
  parameter logic [ADDR_W-1:0] STACK_BASE = ADDR_W'('h0100),
  parameter logic [SP_W-1:0]   SP_RESET   = SP_W'('hFF),
  parameter int unsigned       MAX_BYTES  = 3,
  parameter bit                WRAP       = 1'b1
) (
  input  logic                        ph1,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [1:0]                  cmd_count,
  input  logic [MAX_BYTES*DATA_W-1:0] cmd_data,
  input  logic [SP_W-1:0]             sp_load,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_we,
  output logic                        mem_re,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        rsp_valid,
  output logic [MAX_BYTES*DATA_W-1:0] rsp_data,
  output logic                        rsp_err,
  output logic [SP_W-1:0]             sp,
  output logic                        ovf_sticky,
  output logic                        unf_sticky
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PUSH      = 3'd1;
  localparam logic [2:0] PULL      = 3'd2;
  localparam logic [2:0] PULL_LAST = 3'd3;
  localparam logic [2:0] RESP      = 3'd4;

  localparam logic [1:0] OP_PUSH = 2'd0;
  localparam logic [1:0] OP_PULL = 2'd1;
  localparam logic [1:0] OP_LOAD = 2'd2;

  localparam int unsigned     DW     = MAX_BYTES * DATA_W;
  localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);

  logic [2:0]      state_q, state_d;
  logic [SP_W-1:0] sp_q, sp_d, load_q, load_d, sp_addr;
  logic [1:0]      op_q, op_d, cnt_q, cnt_d, k_q, k_d;
  logic [DW-1:0]   data_q, data_d, rdat_q, rdat_d;
  logic            err_q, err_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [1:0]      n_req;
  logic [SP_W:0]   n_ext, sp_ext1;
  logic            push_ok, pull_ok;

  always_comb begin
    n_req = (cmd_count == 2'd0) ? 2'd1 : cmd_count;
    if (int'(n_req) > int'(MAX_BYTES)) n_req = 2'(MAX_BYTES);
  end

  // Room checks: push needs sp >= n-1, pull needs (max - sp) >= n.
  assign n_ext   = {{(SP_W - 1){1'b0}}, n_req};
  assign sp_ext1 = {1'b0, sp_q} + {{SP_W{1'b0}}, 1'b1};
  assign push_ok = WRAP || (n_ext <= sp_ext1);
  assign pull_ok = WRAP || (n_ext <= {1'b0, ~sp_q});

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    load_d  = load_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    data_d  = data_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    // Read data returns one cycle after its strobe, so pull byte k lands while k+1 is issued.
    if (state_q == PULL || state_q == PULL_LAST) begin
      for (int i = 0; i < int'(MAX_BYTES); i++) begin
        if (int'(k_q) == i + 1) rdat_d[i*DATA_W +: DATA_W] = mem_rdata;
      end
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          cnt_d   = n_req;
          k_d     = 2'd0;
          data_d  = cmd_data;
          load_d  = sp_load;
          rdat_d  = '0;
          err_d   = 1'b0;
          state_d = RESP;
          if (cmd_op == OP_PUSH) begin
            if (push_ok) state_d = PUSH;
            else         err_d   = 1'b1;
          end else if (cmd_op == OP_PULL) begin
            if (pull_ok) state_d = PULL;
            else         err_d   = 1'b1;
          end
        end
      end
      PUSH: begin
        sp_d  = sp_q - SP_ONE;
        if (WRAP && sp_q == '0) ovf_d = 1'b1;
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = RESP;
      end
      PULL: begin
        sp_d = sp_q + SP_ONE;
        if (WRAP && sp_q == '1) unf_d = 1'b1;
        k_d  = k_q + 2'd1;
        if (k_d == cnt_q) state_d = PULL_LAST;
      end
      PULL_LAST: state_d = RESP;
      RESP: begin
        if (op_q == OP_LOAD) begin
          sp_d  = load_q;
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ph1) begin
    if (!reset) begin
      state_q <= IDLE;
      sp_q    <= SP_RESET;
      load_q  <= '0;
      op_q    <= 2'd0;
      cnt_q   <= 2'd0;
      k_q     <= 2'd0;
      data_q  <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      load_q  <= load_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      data_q  <= data_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_comb begin
    mem_wdata = '0;
    for (int i = 0; i < int'(MAX_BYTES); i++) begin
      if (int'(cnt_q) == i + 1) mem_wdata = data_q[i*DATA_W +: DATA_W];
    end
  end

  // Strobes are gated by reset so an abandoned command cannot write on the reset edge.
  assign mem_we     = reset && (state_q == PUSH);
  assign mem_re     = reset && (state_q == PULL);
  assign sp_addr    = (state_q == PULL) ? sp_q + SP_ONE : sp_q;
  assign mem_addr   = STACK_BASE + {{(ADDR_W - SP_W){1'b0}}, sp_addr};
  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_err    = rsp_valid && err_q;
  assign rsp_data   = rdat_q;
  assign sp         = sp_q;
  assign ovf_sticky = ovf_q;
  assign unf_sticky = unf_q;

endmodule
